// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory bus arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_CPU_WS  = 2'd1,
        ST_DMA     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam logic [15:0] ACIA_MASK = 16'hFFFC;
    localparam int          WAIT_W    = 3;
    localparam int          BURST_W   = 4;

    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
        return (addr & ACIA_MASK) == (base & ACIA_MASK);
    endfunction

endpackage

// File: rtl/mem_arb_region.sv
// rtl/mem_arb_region.sv - ACIA window address decode
module mem_arb_region
    import mem_arb_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h8000
) (
    input  logic [15:0] addr,
    output logic        hit
);

    assign hit = in_window(addr, BASE);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - 65C02 / DMA loader memory bus arbiter
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [15:0] ACIA_BASE = 16'h8000,
    parameter int          ACIA_WAIT = 2,
    parameter int          MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rwb,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_rwb,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_cs,
    input  logic [7:0]  mem_rdata
);

    localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(ACIA_WAIT - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_e         state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [7:0]         dma_rdata_q, dma_rdata_d;
    logic               cpu_hit, dma_hit;

    mem_arb_region #(.BASE(ACIA_BASE)) u_cpu_region (.addr(cpu_addr), .hit(cpu_hit));
    mem_arb_region #(.BASE(ACIA_BASE)) u_dma_region (.addr(dma_addr), .hit(dma_hit));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CPU;
            wait_q      <= '0;
            burst_q     <= '0;
            dma_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            burst_q     <= burst_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        burst_d     = burst_q;
        dma_rdata_d = dma_rdata_q;
        cpu_rdy     = 1'b0;
        dma_gnt     = 1'b0;
        dma_ack     = 1'b0;
        dma_err     = 1'b0;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            ST_CPU, ST_RELEASE: begin
                cpu_rdy = 1'b1;
                mem_cs  = 1'b1;
                // ACIA check wins over DMA; RELEASE never grants so the CPU always gets one access
                if (cpu_hit) begin
                    state_d = ST_CPU_WS;
                    wait_d  = WAIT_LOAD;
                end else begin
                    mem_we  = ~cpu_rwb;
                    state_d = (state_q == ST_CPU && dma_req) ? ST_DMA : ST_CPU;
                end
            end
            ST_CPU_WS: begin
                mem_cs = 1'b1;
                if (wait_q == '0) begin
                    mem_we  = ~cpu_rwb;
                    state_d = ST_CPU;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_DMA: begin
                dma_gnt   = 1'b1;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                if (dma_req) begin
                    dma_ack     = 1'b1;
                    dma_rdata_d = mem_rdata;
                    if (dma_hit) begin
                        dma_err = 1'b1;
                    end else begin
                        mem_cs = 1'b1;
                        mem_we = ~dma_rwb;
                    end
                    if (burst_q == BURST_LAST) begin
                        state_d = ST_RELEASE;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end else begin
                    state_d = ST_RELEASE;
                    burst_d = '0;
                end
            end
            default: state_d = ST_CPU;
        endcase

        // A reset edge abandons whatever is in flight, so nothing may strobe on it
        if (reset) begin
            cpu_rdy = 1'b1;
            dma_gnt = 1'b0;
            dma_ack = 1'b0;
            dma_err = 1'b0;
            mem_we  = 1'b0;
            mem_cs  = 1'b0;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rwb;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rwb;
    logic        dma_gnt;
    logic        dma_ack;
    logic        dma_err;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_cs;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(
        .ACIA_BASE(16'h8000),
        .ACIA_WAIT(2),
        .MAX_BURST(4)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rwb(cpu_rwb),
        .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rwb(dma_rwb),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_cs(mem_cs),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    int tg[11]   = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    int tack[11] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0};
    int trdy[11] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};

    initial begin
        int n;
        int k;
        int acks;
        reset = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h11; cpu_rwb = 1'b0;
        dma_req = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'h00; dma_rwb = 1'b0;
        mem_rdata = 8'h00;
        #1;

        // reset held three clocks with a pending loader request
        for (int i = 0; i < 3; i++) begin
            mid();
            check("rst_rdy", 32'(cpu_rdy), 1);
            check("rst_gnt", 32'(dma_gnt), 0);
            check("rst_we", 32'(mem_we), 0);
            next_clk();
        end

        reset = 1'b0; dma_req = 1'b0; cpu_rwb = 1'b1;
        mid();
        check("idle_rdy", 32'(cpu_rdy), 1);
        check("idle_gnt", 32'(dma_gnt), 0);
        check("idle_ack", 32'(dma_ack), 0);
        check("idle_err", 32'(dma_err), 0);
        check("idle_we", 32'(mem_we), 0);
        check("idle_rdata", 32'(dma_rdata), 0);
        check("idle_cs", 32'(mem_cs), 1);
        next_clk();

        // CPU write 0x41 to the ACIA: three clocks, strobe only on the last
        cpu_addr = 16'h8000; cpu_wdata = 8'h41; cpu_rwb = 1'b0;
        mid();
        check("acia0_rdy", 32'(cpu_rdy), 1);
        check("acia0_we", 32'(mem_we), 0);
        next_clk();
        mid();
        check("acia1_rdy", 32'(cpu_rdy), 0);
        check("acia1_we", 32'(mem_we), 0);
        next_clk();
        mid();
        check("acia2_rdy", 32'(cpu_rdy), 0);
        check("acia2_we", 32'(mem_we), 1);
        check("acia2_wdata", 32'(mem_wdata), 32'h41);
        check("acia2_addr", 32'(mem_addr), 32'h8000);
        next_clk();
        cpu_addr = 16'h0100; cpu_rwb = 1'b1;
        mid();
        check("acia3_rdy", 32'(cpu_rdy), 1);
        check("acia3_we", 32'(mem_we), 0);
        next_clk();

        // loader request raised during the ACIA wait
        cpu_addr = 16'h8002; cpu_wdata = 8'h42; cpu_rwb = 1'b0;
        mid();
        check("ws_a_gnt", 32'(dma_gnt), 0);
        next_clk();
        dma_req = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'h55; dma_rwb = 1'b0;
        mid();
        check("ws_b_gnt", 32'(dma_gnt), 0);
        check("ws_b_rdy", 32'(cpu_rdy), 0);
        next_clk();
        mid();
        check("ws_c_gnt", 32'(dma_gnt), 0);
        check("ws_c_we", 32'(mem_we), 1);
        check("ws_c_wdata", 32'(mem_wdata), 32'h42);
        next_clk();
        cpu_addr = 16'h0100; cpu_rwb = 1'b1;
        mid();
        check("ws_d_rdy", 32'(cpu_rdy), 1);
        check("ws_d_gnt", 32'(dma_gnt), 0);
        next_clk();
        mid();
        check("ws_e_gnt", 32'(dma_gnt), 1);
        check("ws_e_ack", 32'(dma_ack), 1);
        check("ws_e_we", 32'(mem_we), 1);
        check("ws_e_addr", 32'(mem_addr), 32'h0300);
        check("ws_e_wdata", 32'(mem_wdata), 32'h55);
        next_clk();
        dma_req = 1'b0;
        mid();
        check("ws_f_gnt", 32'(dma_gnt), 1);
        check("ws_f_ack", 32'(dma_ack), 0);
        next_clk();
        mid();
        check("ws_g_rdy", 32'(cpu_rdy), 1);
        check("ws_g_gnt", 32'(dma_gnt), 0);
        next_clk();

        // six loader writes with bursts capped at four
        n = 0; k = 0; acks = 0; dma_rwb = 1'b0;
        for (int c = 0; c < 11; c++) begin
            dma_req = (n < 6);
            dma_addr = 16'(16'h0200 + n);
            dma_wdata = 8'(8'hA0 + n);
            mid();
            check("burst_gnt", 32'(dma_gnt), tg[c]);
            check("burst_ack", 32'(dma_ack), tack[c]);
            check("burst_rdy", 32'(cpu_rdy), trdy[c]);
            if (tack[c] != 0) begin
                check("burst_addr", 32'(mem_addr), 32'(16'h0200 + k));
                check("burst_we", 32'(mem_we), 1);
                k++;
            end
            if (dma_ack) begin
                n++;
                acks++;
            end
            next_clk();
        end
        check("burst_total", 32'(acks), 6);

        // DMA read of RAM, then an access into the ACIA window
        dma_req = 1'b1; dma_addr = 16'h0400; dma_rwb = 1'b1; mem_rdata = 8'h5A;
        mid();
        check("rd0_gnt", 32'(dma_gnt), 0);
        next_clk();
        mid();
        check("rd1_ack", 32'(dma_ack), 1);
        check("rd1_err", 32'(dma_err), 0);
        check("rd1_cs", 32'(mem_cs), 1);
        check("rd1_we", 32'(mem_we), 0);
        check("rd1_cpu_rdata", 32'(cpu_rdata), 32'h5A);
        next_clk();
        dma_addr = 16'h8001;
        mid();
        check("err_rdata", 32'(dma_rdata), 32'h5A);
        check("err_err", 32'(dma_err), 1);
        check("err_ack", 32'(dma_ack), 1);
        check("err_cs", 32'(mem_cs), 0);
        check("err_we", 32'(mem_we), 0);
        next_clk();
        dma_req = 1'b0;
        mid();
        check("err3_ack", 32'(dma_ack), 0);
        check("err3_err", 32'(dma_err), 0);
        check("err3_gnt", 32'(dma_gnt), 1);
        next_clk();
        mid();
        check("err4_rdy", 32'(cpu_rdy), 1);
        check("err4_gnt", 32'(dma_gnt), 0);
        next_clk();

        // reset landing on the second transfer of a burst
        dma_req = 1'b1; dma_addr = 16'h0600; dma_wdata = 8'h66; dma_rwb = 1'b0;
        mid();
        check("rb0_gnt", 32'(dma_gnt), 0);
        next_clk();
        mid();
        check("rb1_ack", 32'(dma_ack), 1);
        check("rb1_we", 32'(mem_we), 1);
        next_clk();
        dma_addr = 16'h0601; reset = 1'b1;
        mid();
        check("rb2_we", 32'(mem_we), 0);
        check("rb2_ack", 32'(dma_ack), 0);
        next_clk();
        reset = 1'b0; dma_req = 1'b0;
        mid();
        check("rb3_rdy", 32'(cpu_rdy), 1);
        check("rb3_gnt", 32'(dma_gnt), 0);
        check("rb3_we", 32'(mem_we), 0);
        next_clk();
        mid();
        check("rb4_gnt", 32'(dma_gnt), 0);
        check("rb4_we", 32'(mem_we), 0);
        next_clk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ACIA_BASE, 16'h8000, base of 4-byte ACIA window (address[15:2] match).
REQ-002 Parameter ACIA_WAIT, 2, extra clocks per CPU access to the ACIA window; legal range 1..7.
REQ-003 Parameter MAX_BURST, 4, maximum DMA transfers per grant; legal range 1..15.
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_addr / cpu_wdata / cpu_rwb  in  16/8/1  65C02 bus request; rwb=1 is a read.
REQ-007 cpu_rdy  out  1  65C02 RDY; low freezes the CPU, which holds address, data and rwb.
REQ-008 cpu_rdata  out  8  read data to the CPU, equal to mem_rdata.
REQ-009 dma_req / dma_addr / dma_wdata / dma_rwb  in  1/16/8/1  loader request, held until acknowledged.
REQ-010 dma_gnt  out  1  loader owns the bus.
REQ-011 dma_ack  out  1  one transfer completes on this edge.
REQ-012 dma_err  out  1  one-clock pulse: loader addressed the ACIA window.
REQ-013 dma_rdata  out  8  mem_rdata registered on the dma_ack edge.
REQ-014 mem_addr / mem_wdata  out  16/8  muxed from the current owner.
REQ-015 mem_we / mem_cs  out  1/1  write strobe and chip select.
REQ-016 mem_rdata  in  8  memory/peripheral read data, valid combinationally in the same clock.

Function
REQ-017 States: CPU, CPU_WS, DMA, RELEASE; cpu_rdy=1 in CPU and RELEASE, 0 in CPU_WS and DMA (decoded from registered state).
REQ-018 CPU and CPU_WS: mem_addr/mem_wdata from the CPU, mem_cs=1.
REQ-019 CPU to CPU_WS: the current CPU access hits the ACIA window; wait counter loads ACIA_WAIT-1.
REQ-020 CPU_WS: counter decrements each clock; at 0, return to CPU.
REQ-021 ACIA access duration: ACIA_WAIT+1 clocks in total.
REQ-022 CPU to DMA: dma_req=1 and the current CPU access is outside the ACIA window. The CPU access completes on that edge, and the ACIA check has priority over DMA.
REQ-023 Otherwise, CPU stays in CPU.
REQ-024 CPU-side mem_we: equals ~cpu_rwb only on the clock in which the access completes (CPU/RELEASE state for non-ACIA; final CPU_WS clock for ACIA). It is 0 on the earlier wait clocks.
REQ-025 DMA state: dma_gnt=1 and mem_addr/mem_wdata come from the loader.
REQ-026 A DMA transfer occurs on each clock with dma_req=1. dma_ack=1 and mem_we=~dma_rwb, giving one transfer per clock.
REQ-027 A DMA address in the ACIA window suppresses the transfer (mem_cs=0, mem_we=0). dma_err pulses, dma_ack=1, and the request is consumed.
REQ-028 DMA burst counter increments per ack. DMA goes to RELEASE when the count reaches MAX_BURST or when dma_req=0; the counter then clears.
REQ-029 RELEASE: CPU owns the bus for exactly one access. The next state is CPU_WS if that access hits the ACIA window, otherwise CPU; DMA cannot be granted from RELEASE.
REQ-030 Consequence of REQ-029: the CPU always gets at least one access between bursts, so the loader cannot starve the CPU.
REQ-031 dma_req dropping mid-burst: no ack that clock, and the arbiter goes to RELEASE.
REQ-032 dma_req rising during CPU_WS: ignored until the ACIA access completes.

Reset
REQ-033 Reset mid-operation abandons any burst or wait sequence without a further write strobe.
REQ-034 Reset values: state=CPU, cpu_rdy=1, dma_gnt=0, dma_ack=0, dma_err=0, mem_we=0, dma_rdata=8'h00, counters=0.
REQ-035 Reset dominates all other inputs on the same edge.

Structure
REQ-036 Package mem_arb_pkg holds the state enum, ACIA window mask, and counter widths (3-bit wait, 4-bit burst).
REQ-037 The ACIA-window compare lives in one sub-module, mem_arb_region, instantiated twice (CPU and DMA address).
REQ-038 The remaining logic is a single registered-state FSM with a combinational output mux.

Verification
REQ-039 Reset held 3 clocks with dma_req=1: cpu_rdy=1, dma_gnt=0, mem_we=0 throughout.
REQ-040 CPU write 8'h41 to 16'h8000, ACIA_WAIT=2: cpu_rdy low for 2 clocks; mem_we high only on the 3rd clock, with mem_wdata=8'h41.
REQ-041 dma_req held with 6 pending writes to 16'h0200..16'h0205, MAX_BURST=4: 4 acks, 1 RELEASE clock with cpu_rdy=1, then 2 acks.
REQ-042 DMA read of 16'h8001: dma_err pulse, dma_ack pulse, mem_cs=0, no mem_we.
REQ-043 dma_req asserted during CPU_WS: no grant until the ACIA access completes; the grant then arrives on the next CPU-state clock.
REQ-044 Reset asserted during the 2nd DMA transfer: next clock state=CPU, dma_gnt=0, and no further writes occur.
